// File: rtl/fft_frame_ctrl.sv
// Frame sequencer for a 32-point SDF FFT core: buffers an input frame, replays it as a
// gap-free burst, captures the result frame and returns it over a backpressured stream.
module fft_frame_ctrl #(
  parameter int unsigned POINTS     = 32,
  parameter int unsigned IN_W       = 12,
  parameter int unsigned OUT_W      = 16,
  parameter int unsigned CLR_CYCLES = 2,
  parameter int unsigned TIMEOUT    = 255
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    i_s_valid,
  output logic                    o_s_ready,
  input  logic signed [IN_W-1:0]  i_s_re,
  input  logic signed [IN_W-1:0]  i_s_im,
  output logic                    o_m_valid,
  input  logic                    i_m_ready,
  output logic signed [OUT_W-1:0] o_m_re,
  output logic signed [OUT_W-1:0] o_m_im,
  output logic                    o_m_last,
  output logic                    o_core_rst,
  output logic                    o_core_in_valid,
  output logic signed [IN_W-1:0]  o_core_din_r,
  output logic signed [IN_W-1:0]  o_core_din_i,
  input  logic                    i_core_out_valid,
  input  logic signed [OUT_W-1:0] i_core_dout_r,
  input  logic signed [OUT_W-1:0] i_core_dout_i,
  output logic                    o_busy,
  output logic [15:0]             o_frame_cnt,
  output logic                    o_timeout_err
);

  localparam int unsigned AW   = $clog2(POINTS);
  localparam int unsigned CW_P = AW + 1;
  localparam int unsigned CW_T = $clog2(TIMEOUT + 1);
  // The shared counter must also span the WAIT timeout.
  localparam int unsigned CW   = (CW_P > CW_T) ? CW_P : CW_T;

  localparam logic [CW-1:0] PtsLast  = CW'(POINTS - 1);
  localparam logic [CW-1:0] CaptLast = CW'(POINTS - 2);
  localparam logic [CW-1:0] ClrLast  = CW'(CLR_CYCLES - 1);
  localparam logic [CW-1:0] ToLast   = CW'(TIMEOUT - 1);

  typedef enum logic [2:0] {StClr, StLoad, StFeed, StWait, StCapt, StOut} state_e;

  state_e                  r_state, w_state_nxt;
  logic [CW-1:0]           r_cnt, w_cnt_nxt;
  logic                    r_core_rst, r_core_in_valid, r_timeout_err;
  logic signed [IN_W-1:0]  r_core_din_r, r_core_din_i;
  logic [15:0]             r_frame_cnt;
  logic                    w_in_hs, w_out_hs, w_timeout;
  logic                    w_obuf_we;
  logic [AW-1:0]           w_obuf_idx;

  logic signed [IN_W-1:0]  r_ibuf_re [POINTS];
  logic signed [IN_W-1:0]  r_ibuf_im [POINTS];
  logic signed [OUT_W-1:0] r_obuf_re [POINTS];
  logic signed [OUT_W-1:0] r_obuf_im [POINTS];

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_in_hs     = 1'b0;
    w_out_hs    = 1'b0;
    w_timeout   = 1'b0;
    w_obuf_we   = 1'b0;
    w_obuf_idx  = '0;
    unique case (r_state)
      StClr: begin
        if (r_cnt == ClrLast) begin
          w_state_nxt = StLoad;
          w_cnt_nxt   = '0;
        end else begin
          w_cnt_nxt = r_cnt + 1'b1;
        end
      end
      StLoad: begin
        if (i_s_valid) begin
          w_in_hs = 1'b1;
          if (r_cnt == PtsLast) begin
            w_state_nxt = StFeed;
            w_cnt_nxt   = '0;
          end else begin
            w_cnt_nxt = r_cnt + 1'b1;
          end
        end
      end
      StFeed: begin
        if (r_cnt == PtsLast) begin
          w_state_nxt = StWait;
          w_cnt_nxt   = '0;
        end else begin
          w_cnt_nxt = r_cnt + 1'b1;
        end
      end
      StWait: begin
        if (i_core_out_valid) begin
          w_obuf_we   = 1'b1;
          w_state_nxt = StCapt;
          w_cnt_nxt   = '0;
        end else if (r_cnt == ToLast) begin
          w_timeout   = 1'b1;
          w_state_nxt = StClr;
          w_cnt_nxt   = '0;
        end else begin
          w_cnt_nxt = r_cnt + 1'b1;
        end
      end
      StCapt: begin
        // obuf[0] came with the first valid cycle, so CAPT fills from index 1.
        w_obuf_we  = 1'b1;
        w_obuf_idx = r_cnt[AW-1:0] + AW'(1);
        if (r_cnt == CaptLast) begin
          w_state_nxt = StOut;
          w_cnt_nxt   = '0;
        end else begin
          w_cnt_nxt = r_cnt + 1'b1;
        end
      end
      StOut: begin
        if (i_m_ready) begin
          w_out_hs = 1'b1;
          if (r_cnt == PtsLast) begin
            w_state_nxt = StClr;
            w_cnt_nxt   = '0;
          end else begin
            w_cnt_nxt = r_cnt + 1'b1;
          end
        end
      end
      default: begin
        w_state_nxt = StClr;
        w_cnt_nxt   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state         <= StClr;
      r_cnt           <= '0;
      r_core_rst      <= 1'b1;
      r_core_in_valid <= 1'b0;
      r_core_din_r    <= '0;
      r_core_din_i    <= '0;
      r_frame_cnt     <= '0;
      r_timeout_err   <= 1'b0;
    end else begin
      r_state         <= w_state_nxt;
      r_cnt           <= w_cnt_nxt;
      r_core_rst      <= (w_state_nxt == StClr);
      r_core_in_valid <= (w_state_nxt == StFeed);
      if (w_state_nxt == StFeed) begin
        r_core_din_r <= r_ibuf_re[w_cnt_nxt[AW-1:0]];
        r_core_din_i <= r_ibuf_im[w_cnt_nxt[AW-1:0]];
      end
      if (w_timeout) r_timeout_err <= 1'b1;
      if (w_out_hs && (r_cnt == PtsLast)) r_frame_cnt <= r_frame_cnt + 16'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (w_in_hs) begin
      r_ibuf_re[r_cnt[AW-1:0]] <= i_s_re;
      r_ibuf_im[r_cnt[AW-1:0]] <= i_s_im;
    end
    if (w_obuf_we) begin
      r_obuf_re[w_obuf_idx] <= i_core_dout_r;
      r_obuf_im[w_obuf_idx] <= i_core_dout_i;
    end
  end

  assign o_s_ready       = (r_state == StLoad);
  assign o_m_valid       = (r_state == StOut);
  assign o_m_re          = o_m_valid ? r_obuf_re[r_cnt[AW-1:0]] : '0;
  assign o_m_im          = o_m_valid ? r_obuf_im[r_cnt[AW-1:0]] : '0;
  assign o_m_last        = o_m_valid && (r_cnt == PtsLast);
  assign o_core_rst      = r_core_rst;
  assign o_core_in_valid = r_core_in_valid;
  assign o_core_din_r    = r_core_din_r;
  assign o_core_din_i    = r_core_din_i;
  assign o_busy          = (r_state != StLoad) || (r_cnt != '0);
  assign o_frame_cnt     = r_frame_cnt;
  assign o_timeout_err   = r_timeout_err;

endmodule

// File: tb/tb_fft_frame_ctrl.sv
// Randomized bench for fft_frame_ctrl: a behavioural FFT core (DFT, bit-reversed emission)
// drives the core side; results are checked against a DFT of the samples sent.
module tb_fft_frame_ctrl;
  localparam int P   = 32;
  localparam int LAT = 6;
  localparam int TO  = 255;

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  logic               s_valid = 1'b0, s_ready;
  logic signed [11:0] s_re = '0, s_im = '0;
  logic               m_valid, m_ready = 1'b0, m_last;
  logic signed [15:0] m_re, m_im;
  logic               core_rst, core_in_valid, core_ov;
  logic signed [11:0] core_din_r, core_din_i;
  logic signed [15:0] core_dr, core_di;
  logic               busy, timeout_err;
  logic [15:0]        frame_cnt;

  fft_frame_ctrl dut (
    .clk              (clk),
    .reset            (reset),
    .i_s_valid        (s_valid),
    .o_s_ready        (s_ready),
    .i_s_re           (s_re),
    .i_s_im           (s_im),
    .o_m_valid        (m_valid),
    .i_m_ready        (m_ready),
    .o_m_re           (m_re),
    .o_m_im           (m_im),
    .o_m_last         (m_last),
    .o_core_rst       (core_rst),
    .o_core_in_valid  (core_in_valid),
    .o_core_din_r     (core_din_r),
    .o_core_din_i     (core_din_i),
    .i_core_out_valid (core_ov),
    .i_core_dout_r    (core_dr),
    .i_core_dout_i    (core_di),
    .o_busy           (busy),
    .o_frame_cnt      (frame_cnt),
    .o_timeout_err    (timeout_err)
  );

  int checks = 0, failures = 0;
  int exp_frames = 0;
  int fr[P], fi[P];
  int rec_re[P], rec_im[P], base_re[P], base_im[P];
  bit mute = 1'b0;

  task automatic check(input string tag, input logic signed [63:0] obs,
                       input logic signed [63:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic int rnd(input real r);
    return (r >= 0.0) ? $rtoi(r + 0.5) : -$rtoi(-r + 0.5);
  endfunction

  function automatic int bitrev(input int k);
    int r = 0;
    for (int b = 0; b < 5; b++) if (k[b]) r |= (1 << (4 - b));
    return r;
  endfunction

  function automatic int dft(input int xr[P], input int xi[P], input int k, input bit im);
    real sr = 0.0, si = 0.0, a;
    for (int n = 0; n < P; n++) begin
      a  = -2.0 * 3.14159265358979 * k * n / P;
      sr += xr[n] * $cos(a) - xi[n] * $sin(a);
      si += xr[n] * $sin(a) + xi[n] * $cos(a);
    end
    return im ? rnd(si) : rnd(sr);
  endfunction

  // Core model: sticky out_valid, bins emitted in bit-reversed order after LAT idle cycles.
  int cxr[P], cxi[P];
  int c_in, c_lat, c_out;
  always @(posedge clk or posedge core_rst) begin
    if (core_rst) begin
      c_in <= 0; c_lat <= 0; c_out <= 0;
      core_ov <= 1'b0; core_dr <= '0; core_di <= '0;
    end else if (core_in_valid && c_in < P) begin
      cxr[c_in] <= int'(core_din_r);
      cxi[c_in] <= int'(core_din_i);
      c_in      <= c_in + 1;
    end else if (c_in == P && !mute) begin
      if (c_lat < LAT) c_lat <= c_lat + 1;
      else if (c_out < P) begin
        core_ov <= 1'b1;
        core_dr <= 16'(dft(cxr, cxi, bitrev(c_out), 1'b0));
        core_di <= 16'(dft(cxr, cxi, bitrev(c_out), 1'b1));
        c_out   <= c_out + 1;
      end
    end
  end

  int run = 0, last_run = 0;
  always @(negedge clk) begin
    if (core_in_valid) run <= run + 1;
    else if (run != 0) begin
      last_run <= run;
      run      <= 0;
    end
  end

  task automatic send_frame(input int mode);
    int idx = 0, cyc = 0;
    bit tg = 1'b0;
    while (idx < P && cyc < 2000) begin
      @(negedge clk);
      cyc++;
      case (mode)
        0:       s_valid = 1'b1;
        1:       begin s_valid = tg; tg = ~tg; end
        default: s_valid = 1'($urandom_range(1));
      endcase
      s_re = 12'(fr[idx]);
      s_im = 12'(fi[idx]);
      if (s_valid && s_ready) idx++;
    end
    if (idx < P) check("load_timeout", idx, P);
    // Keep offering a sample across the LOAD->FEED boundary.
    @(negedge clk);
    s_valid = 1'b1;
    s_re    = 12'sd77;
    check("s_ready_in_feed", s_ready, 0);
    check("feed_start", core_in_valid, 1);
    @(negedge clk);
    check("s_ready_in_feed2", s_ready, 0);
    s_valid = 1'b0;
  endtask

  task automatic recv_frame(input int duty, input int n_stop, input string tag);
    int n = 0, cyc = 0;
    bit stalled = 1'b0;
    logic signed [15:0] pr = '0, pim = '0;
    logic pl = 1'b0;
    while (n < n_stop && cyc < 3000) begin
      @(negedge clk);
      cyc++;
      if (stalled) begin
        check({tag, "_hold_re"}, m_re, pr);
        check({tag, "_hold_im"}, m_im, pim);
        check({tag, "_hold_last"}, m_last, pl);
      end
      m_ready = ($urandom_range(99) < duty);
      stalled = 1'b0;
      if (m_valid) begin
        if (m_ready) begin
          check({tag, "_re"}, m_re, dft(fr, fi, bitrev(n), 1'b0));
          check({tag, "_im"}, m_im, dft(fr, fi, bitrev(n), 1'b1));
          check({tag, "_last"}, m_last, (n == P - 1));
          rec_re[n] = int'(m_re);
          rec_im[n] = int'(m_im);
          n++;
        end else begin
          stalled = 1'b1;
          pr = m_re; pim = m_im; pl = m_last;
        end
      end
    end
    if (n < n_stop) check({tag, "_out_timeout"}, n, n_stop);
  endtask

  task automatic run_frame(input int mode, input int duty, input string tag);
    send_frame(mode);
    recv_frame(duty, P, tag);
    @(negedge clk);
    m_ready = 1'b0;
    exp_frames++;
    check({tag, "_frame_cnt"}, frame_cnt, exp_frames);
    check({tag, "_m_valid_after"}, m_valid, 0);
    check({tag, "_feed_len"}, last_run, P);
  endtask

  task automatic rand_frame();
    for (int i = 0; i < P; i++) begin
      fr[i] = $urandom_range(1000) - 500;
      fi[i] = $urandom_range(1000) - 500;
    end
  endtask

  initial begin
    int n, cr;
    #1 reset = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_core_rst", core_rst, 1);
    check("rst_s_ready", s_ready, 0);
    check("rst_m_valid", m_valid, 0);
    check("rst_m_last", m_last, 0);
    check("rst_core_in_valid", core_in_valid, 0);
    check("rst_frame_cnt", frame_cnt, 0);
    check("rst_timeout_err", timeout_err, 0);
    reset = 1'b0;
    n = 0;
    while (!s_ready && n < 20) begin @(negedge clk); n++; end
    check("idle_s_ready", s_ready, 1);
    check("idle_busy", busy, 0);
    check("idle_core_rst", core_rst, 0);

    for (int i = 0; i < P; i++) begin fr[i] = 0; fi[i] = 0; end
    fr[0] = 100;
    run_frame(0, 100, "impulse");
    check("impulse_bin0", rec_re[0], 100);
    check("impulse_bin31", rec_re[31], 100);

    for (int i = 0; i < P; i++) begin fr[i] = 10; fi[i] = 0; end
    run_frame(0, 100, "dc");
    check("dc_first", rec_re[0], 320);
    check("dc_other", rec_re[7], 0);

    rand_frame();
    run_frame(2, 100, "rand");
    base_re = rec_re;
    base_im = rec_im;
    run_frame(0, 30, "bp");
    for (int i = 0; i < P; i++) begin
      check("bp_same_re", rec_re[i], base_re[i]);
      check("bp_same_im", rec_im[i], base_im[i]);
    end

    for (int i = 0; i < P; i++) begin fr[i] = 0; fi[i] = 0; end
    fr[0] = 100;
    run_frame(1, 100, "gappy");

    mute = 1'b1;
    rand_frame();
    send_frame(0);
    n = 0;
    while (core_in_valid && n < 100) begin @(negedge clk); n++; end
    n = 0;
    while (!timeout_err && n < 400) begin n++; @(negedge clk); end
    check("timeout_wait_cycles", n, TO);
    cr = 0;
    while (core_rst && cr < 10) begin cr++; @(negedge clk); end
    check("timeout_clr_cycles", cr, 2);
    check("timeout_reload_ready", s_ready, 1);
    check("timeout_frame_cnt", frame_cnt, exp_frames);
    mute = 1'b0;
    rand_frame();
    run_frame(2, 60, "post_to");
    check("timeout_sticky", timeout_err, 1);

    rand_frame();
    send_frame(0);
    recv_frame(100, 10, "partial");
    @(posedge clk);
    #2;
    check("pre_rst_m_valid", m_valid, 1);
    reset = 1'b1;
    #1;
    check("mid_rst_m_valid", m_valid, 0);
    check("mid_rst_core_rst", core_rst, 1);
    check("mid_rst_frame_cnt", frame_cnt, 0);
    check("mid_rst_timeout_err", timeout_err, 0);
    m_ready = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    exp_frames = 0;
    rand_frame();
    run_frame(0, 100, "after_rst");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
